// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master round-robin AHB arbiter with burst/lock hold and address/data-phase owner tracking
module ahb_arbiter #(
  parameter logic DEFAULT_MASTER = 1'b0
) (
  input  logic       hclk_i,
  input  logic       hresetn_i,
  input  logic       hbusreq_1_i,
  input  logic       hbusreq_2_i,
  input  logic       hlock_1_i,
  input  logic       hlock_2_i,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  input  logic       hready_i,
  input  logic       hresp_i,
  output logic       hgrant_1_o,
  output logic       hgrant_2_o,
  output logic       hmaster_o,
  output logic       hmaster_d_o,
  output logic       hmastlock_o
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  logic       g_q, g_d, rr_q, rr_d, hmaster_q, hmaster_dq, hmastlock_q;
  logic [3:0] beats_q, beats_d, len_m1;
  logic [1:0] req, lck;
  logic       arb_ok, hold, win;
  assign req = {hbusreq_2_i, hbusreq_1_i};
  assign lck = {hlock_2_i, hlock_1_i};
  // remaining address beats implied by a NONSEQ of the current burst type
  always_comb begin
    case (hburst_i)
      3'b010, 3'b011: len_m1 = 4'd3;
      3'b100, 3'b101: len_m1 = 4'd7;
      3'b110, 3'b111: len_m1 = 4'd15;
      default:        len_m1 = 4'd0;
    endcase
  end
  // beat tracking; an ERROR response aborts the burst even during its wait cycle
  always_comb begin
    beats_d = hresp_i              ? 4'd0 :
              !hready_i            ? beats_q :
              htrans_i == TR_NONSEQ ? len_m1 :
              htrans_i == TR_SEQ    ? (beats_q == 4'd0 ? 4'd0 : beats_q - 4'd1) :
              htrans_i == TR_BUSY   ? beats_q : 4'd0;
  end
  // arbitration: lock hold, then round-robin, then single requester, then park
  always_comb begin
    arb_ok = hready_i && (beats_d == 4'd0);
    hold   = req[g_q] && lck[g_q];
    win    = hold    ? g_q :
             &req    ? ~rr_q :
             req[0]  ? 1'b0 :
             req[1]  ? 1'b1 : DEFAULT_MASTER;
    g_d    = arb_ok ? win : g_q;
    rr_d   = (arb_ok && |req) ? win : rr_q;
  end
  // state registers; owner pipeline advances only on accepted transfers
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      g_q         <= DEFAULT_MASTER;
      rr_q        <= DEFAULT_MASTER;
      beats_q     <= 4'd0;
      hmaster_q   <= DEFAULT_MASTER;
      hmaster_dq  <= DEFAULT_MASTER;
      hmastlock_q <= 1'b0;
    end else begin
      g_q     <= g_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
      if (hready_i) begin
        hmaster_q   <= g_q;
        hmaster_dq  <= hmaster_q;
        hmastlock_q <= lck[g_q];
      end
    end
  end
  assign hgrant_1_o  = ~g_q;
  assign hgrant_2_o  = g_q;
  assign hmaster_o   = hmaster_q;
  assign hmaster_d_o = hmaster_dq;
  assign hmastlock_o = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed vector table, reset/abort sequences and randomized model comparison
module tb_ahb_arbiter;
  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
  logic clk = 1'b0, rstn = 1'b1;
  logic r1, r2, l1, l2, rdy, rsp;
  logic [1:0] tr;
  logic [2:0] bu;
  logic g1, g2, hm, hmd, lk;
  int total = 0, bad = 0;
  typedef struct {
    logic r1, r2, l1, l2;
    logic [1:0] tr;
    logic [2:0] bu;
    logic rdy, rsp;
    logic g1, g2, hm, hmd, lk;
  } vec_t;
  vec_t tbl[$];
  int blen[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  int mg, mrr, mb, mhm, mhmd, mlk;
  always #5 clk = ~clk;
  ahb_arbiter #(.DEFAULT_MASTER(1'b0)) dut (
    .hclk_i(clk), .hresetn_i(rstn),
    .hbusreq_1_i(r1), .hbusreq_2_i(r2), .hlock_1_i(l1), .hlock_2_i(l2),
    .htrans_i(tr), .hburst_i(bu), .hready_i(rdy), .hresp_i(rsp),
    .hgrant_1_o(g1), .hgrant_2_o(g2), .hmaster_o(hm), .hmaster_d_o(hmd), .hmastlock_o(lk)
  );
  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string nm, input logic eg1, eg2, ehm, ehmd, elk);
    chk({nm, ".hgrant_1"}, g1, eg1);
    chk({nm, ".hgrant_2"}, g2, eg2);
    chk({nm, ".hmaster"}, hm, ehm);
    chk({nm, ".hmaster_d"}, hmd, ehmd);
    chk({nm, ".hmastlock"}, lk, elk);
  endtask
  task automatic add(input logic a1, a2, k1, k2, input logic [1:0] t, input logic [2:0] b,
                     input logic y, e, eg1, eg2, ehm, ehmd, elk);
    vec_t v;
    v.r1 = a1; v.r2 = a2; v.l1 = k1; v.l2 = k2; v.tr = t; v.bu = b; v.rdy = y; v.rsp = e;
    v.g1 = eg1; v.g2 = eg2; v.hm = ehm; v.hmd = ehmd; v.lk = elk;
    tbl.push_back(v);
  endtask
  task automatic drv(input logic a1, a2, k1, k2, input logic [1:0] t, input logic [2:0] b, input logic y, e);
    r1 = a1; r2 = a2; l1 = k1; l2 = k2; tr = t; bu = b; rdy = y; rsp = e;
  endtask
  // reference: beats remaining computed from burst length arithmetic, grant chosen from the rule list
  task automatic model_step();
    int nb, ng, nrr;
    bit want[2], lockv[2];
    want[0] = r1; want[1] = r2; lockv[0] = l1; lockv[1] = l2;
    ng = mg; nrr = mrr;
    if (rsp) nb = 0;
    else if (!rdy) nb = mb;
    else if (tr == N) nb = blen[bu] - 1;
    else if (tr == S) nb = (mb > 0) ? mb - 1 : 0;
    else if (tr == B) nb = mb;
    else nb = 0;
    if (rdy && nb == 0) begin
      if (want[mg] && lockv[mg]) ng = mg;
      else if (want[0] && want[1]) ng = 1 - mrr;
      else if (want[0]) ng = 0;
      else if (want[1]) ng = 1;
      else ng = 0;
      if (want[0] || want[1]) nrr = ng;
    end
    if (rdy) begin
      mhmd = mhm;
      mhm = mg;
      mlk = int'(lockv[mg]);
    end
    mg = ng; mrr = nrr; mb = nb;
  endtask
  initial begin
    drv(0, 0, 0, 0, I, 3'd0, 1, 0);
    #2 rstn = 1'b0;
    #1 chk_all("reset", 1, 0, 0, 0, 0);
    @(posedge clk); #1 rstn = 1'b1;
    // park handover
    add(0,1,0,0, I,3'd0,1,0, 0,1,0,0,0);
    add(0,1,0,0, N,3'd0,1,0, 0,1,1,0,0);
    add(0,0,0,0, I,3'd0,1,0, 1,0,1,1,0);
    add(0,0,0,0, I,3'd0,1,0, 1,0,0,1,0);
    add(0,0,0,0, I,3'd0,1,0, 1,0,0,0,0);
    add(1,0,0,0, I,3'd0,1,0, 1,0,0,0,0);
    // INCR4 hold by master 1, handover at 4th beat
    add(1,1,0,0, N,3'd3,1,0, 1,0,0,0,0);
    add(1,1,0,0, S,3'd3,1,0, 1,0,0,0,0);
    add(1,1,0,0, S,3'd3,1,0, 1,0,0,0,0);
    add(1,1,0,0, S,3'd3,1,0, 0,1,0,0,0);
    // INCR4 by master 2 with two wait states
    add(1,1,0,0, N,3'd3,1,0, 0,1,1,0,0);
    add(1,1,0,0, S,3'd3,1,0, 0,1,1,1,0);
    add(1,1,0,0, S,3'd3,0,0, 0,1,1,1,0);
    add(1,1,0,0, S,3'd3,0,0, 0,1,1,1,0);
    add(1,1,0,0, S,3'd3,1,0, 0,1,1,1,0);
    add(1,1,0,0, S,3'd3,1,0, 1,0,1,1,0);
    // round-robin SINGLEs
    add(1,1,0,0, N,3'd0,1,0, 0,1,0,1,0);
    add(1,1,0,0, N,3'd0,1,0, 1,0,1,0,0);
    add(1,1,0,0, N,3'd0,1,0, 0,1,0,1,0);
    add(1,1,0,0, N,3'd0,1,0, 1,0,1,0,0);
    // lock by master 2
    add(1,1,0,1, N,3'd0,1,0, 0,1,0,1,0);
    add(1,1,0,1, N,3'd0,1,0, 0,1,1,0,1);
    add(1,1,0,1, N,3'd0,1,0, 0,1,1,1,1);
    add(1,1,0,0, N,3'd0,1,0, 1,0,1,1,0);
    // ERROR on beat 2 of INCR8
    add(1,1,0,0, N,3'd5,1,0, 1,0,0,1,0);
    add(1,1,0,0, S,3'd5,1,0, 1,0,0,0,0);
    add(1,1,0,0, S,3'd5,0,1, 1,0,0,0,0);
    add(1,1,0,0, S,3'd5,1,1, 0,1,0,0,0);
    // IDLE on beat 3 of INCR16
    add(1,1,0,0, N,3'd7,1,0, 0,1,1,0,0);
    add(1,1,0,0, S,3'd7,1,0, 0,1,1,1,0);
    add(1,1,0,0, I,3'd7,1,0, 1,0,1,1,0);
    add(0,0,0,0, I,3'd0,1,0, 1,0,0,1,0);
    foreach (tbl[i]) begin
      drv(tbl[i].r1, tbl[i].r2, tbl[i].l1, tbl[i].l2, tbl[i].tr, tbl[i].bu, tbl[i].rdy, tbl[i].rsp);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].g1, tbl[i].g2, tbl[i].hm, tbl[i].hmd, tbl[i].lk);
    end
    // asynchronous reset in the middle of a locked INCR8
    drv(0, 1, 0, 1, I, 3'd0, 1, 0);
    @(posedge clk); #1 drv(0, 1, 0, 1, N, 3'd5, 1, 0);
    @(posedge clk); #1 drv(0, 1, 0, 1, S, 3'd5, 1, 0);
    @(posedge clk); #1;
    chk("pre_reset.hgrant_2", g2, 1'b1);
    chk("pre_reset.hmastlock", lk, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_all("mid_burst_reset", 1, 0, 0, 0, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_regrant.hgrant_2", g2, 1'b1);
    // randomized comparison against the reference model
    drv(0, 0, 0, 0, I, 3'd0, 1, 0);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    mg = 0; mrr = 0; mb = 0; mhm = 0; mhmd = 0; mlk = 0;
    for (int n = 0; n < 2000; n++) begin
      drv($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      model_step();
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", n), mg == 0, mg == 1, mhm[0], mhmd[0], mlk[0]);
      chk($sformatf("rand%0d.onehot", n), g1 ^ g2, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB arbiter and ownership tracker for the shared RAM/ROM slave bus. Grants the address bus to one of two masters using round-robin priority, holds the grant across fixed-length bursts and locked sequences, and parks on a default master when neither master requests. Publishes the address-phase owner (drives the master-side address/control mux) and the data-phase owner (routes the read-data/hready/hresp returned by the slave response mux back to the correct master).

## Interface
- DEFAULT_MASTER, 0, park/reset owner; 0 = master 1, 1 = master 2
- hclk  in  1  bus clock; all state on rising edge
- hresetn  in  1  asynchronous, active-low reset
- hbusreq_1, hbusreq_2  in  1  bus request from master 1 / 2
- hlock_1, hlock_2  in  1  locked-access request from master 1 / 2
- htrans  in  2  transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hburst  in  3  burst type of the current owner (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16)
- hready  in  1  bus ready from the slave response mux
- hresp  in  1  slave response from the response mux; 1 = ERROR
- hgrant_1, hgrant_2  out  1  one-hot grant, registered
- hmaster  out  1  address-phase owner index, registered
- hmaster_d  out  1  data-phase owner index, registered
- hmastlock  out  1  current address phase is locked, registered

## Operation
- Internal state: grant index g, last-winner pointer rr, 4-bit beats_left (address beats remaining in the current fixed burst).
- Burst length L: SINGLE/INCR = 1; x4 = 4; x8 = 8; x16 = 16. INCR is re-arbitrated every beat.
- beats_next, evaluated in every cycle with hready=1:
  - NONSEQ: L-1.
  - SEQ: beats_left-1, saturating at 0.
  - BUSY: beats_left.
  - IDLE: 0 (early burst termination).
- With hready=0, beats_left holds.
- hresp=1 in any cycle forces beats_next=0 (burst aborted).
- Arbitration point: arb_ok = hready and beats_next==0.
- When arb_ok, g is chosen in this priority order:
  - The current g keeps the grant while its hlock and hbusreq are both 1 (lock hold).
  - Both masters requesting: the master other than rr wins.
  - One master requesting: that master wins.
  - No requests: DEFAULT_MASTER.
- rr is set to the winner whenever a requesting master is granted.
- When arb_ok is low, g holds.
- hgrant_1 = (g==0) and hgrant_2 = (g==1); exactly one is always high.
- On each hready=1 edge:
  - hmaster <= g.
  - hmaster_d <= hmaster.
  - hmastlock <= hlock of the master in g.
- With hready=0, hmaster, hmaster_d and hmastlock all hold.

## Timing
- Reset values (async assert, synchronous use after deassert):
  - g = hmaster = hmaster_d = rr = DEFAULT_MASTER.
  - beats_left = 0; hmastlock = 0.
  - Grant line of DEFAULT_MASTER = 1; the other grant line = 0.
- Reset mid-burst: state returns to reset values immediately. The burst is abandoned with no recovery.
- Grant latency: a request to an idle, parked bus is granted 1 cycle after hbusreq is sampled (hready=1). hmaster follows at the next hready=1 edge.
- Handover after a fixed burst: g changes at the edge accepting the last SEQ beat (beats_left 1->0). hmaster changes at the following hready=1 edge.
- A NONSEQ with L>1 accepted with hready=1 blocks re-grant at that edge.
- Wait states (hready=0) freeze g, hmaster, hmaster_d, hmastlock and beats_left.
- ERROR, two-cycle response:
  - Cycle 1 (hresp=1, hready=0): beats_left cleared.
  - Cycle 2 (hresp=1, hready=1): arbitration proceeds.
- Simultaneous requests on the same cycle resolve by rr. With equal demand, ownership alternates at each arbitration point.
- Outputs are glitch-free flops. There is no combinational path from inputs to outputs.

## Test plan
- Reset, no requests: check hgrant_1=1, hgrant_2=0, hmaster=0, hmastlock=0 with DEFAULT_MASTER=0. Assert hresetn low mid-INCR8 and check the same values return asynchronously.
- Park handover: hbusreq_2=1 only, hready=1 -> hgrant_2=1 after 1 cycle and hmaster=1 after 2 cycles. Then drop hbusreq_2 -> grant parks back on master 1.
- INCR4 hold: master 1 issues NONSEQ+3 SEQ with hburst=011 while hbusreq_2=1 throughout.
  - hgrant_1 stays 1 for all 4 address beats.
  - hgrant_2 rises at the edge accepting the 4th beat.
  - Repeat with hready=0 inserted on beat 2: the grant is extended by exactly the stalled cycles.
- Round-robin: both masters hold hbusreq high and issue SINGLE NONSEQ every cycle -> hmaster alternates 0,1,0,1.
- Lock: master 2 requests with hlock_2=1 and issues SINGLEs while master 1 requests -> master 2 keeps the grant and hmastlock=1 on its phases. Drop hlock_2 -> master 1 is granted at the next arbitration point.
- Error/early termination:
  - ERROR (hresp=1 for 2 cycles) on beat 2 of an INCR8 -> grant passes to the waiting master after the second error cycle.
  - IDLE on beat 3 of an INCR16 -> beats_left=0 and re-grant occurs at that edge.
